// File: rtl/sdram_responder.sv
// sdram_responder
//   Device-side model of a single x16 SDR SDRAM (4 banks, 13-bit address)
//   built from block RAM, so the SDRAM controller can be exercised on-chip.
//   It decodes controller commands, tracks the open row of each bank, and
//   honours the loaded CAS latency and burst length. Row bits above ROW_KEEP
//   alias onto the same storage.
//
// Ports
//   clk_clk       controller's SDRAM clock
//   reset_reset   synchronous active-high reset
//   sdram_addr    A[12:0]
//   sdram_ba      bank address
//   sdram_cs_n / ras_n / cas_n / we_n   command strobes (active low)
//   sdram_cke     clock enable; 0 freezes every register
//   sdram_dqm     byte mask for writes, bit1 = dq[15:8]
//   sdram_dq_in   write data
//   sdram_dq_out  read data
//   sdram_dq_oe   read data drive enable
//   init_done     set by the first valid LOAD MODE
//   err_flags     sticky: [0] RD/WR to closed bank, [1] ACTIVE to open bank,
//                 [2] command before init, [3] unsupported CAS latency
module sdram_responder #(
  parameter int COL_BITS = 9,
  parameter int ROW_KEEP = 3,
  parameter int MEM_AW   = 14
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [12:0] sdram_addr,
  input  logic [1:0]  sdram_ba,
  input  logic        sdram_cs_n,
  input  logic        sdram_ras_n,
  input  logic        sdram_cas_n,
  input  logic        sdram_we_n,
  input  logic        sdram_cke,
  input  logic [1:0]  sdram_dqm,
  input  logic [15:0] sdram_dq_in,
  output logic [15:0] sdram_dq_out,
  output logic        sdram_dq_oe,
  output logic        init_done,
  output logic [3:0]  err_flags
);

  typedef enum logic [2:0] {
    CMD_LMR = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
    CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_BST = 3'b110, CMD_NOP = 3'b111
  } cmd_e;

  typedef enum logic [1:0] {B_IDLE, B_READ, B_WRITE} burst_e;

  cmd_e cmd;
  assign cmd = sdram_cs_n ? CMD_NOP : cmd_e'({sdram_ras_n, sdram_cas_n, sdram_we_n});

  // Control state (reset)
  burst_e      state_q, state_d;
  logic        cl3_q, cl3_d;          // 1: CL=3, 0: CL=2
  logic [2:0]  bl_mask_q, bl_mask_d;  // burst length - 1
  logic        init_q, init_d;
  logic [3:0]  open_q, open_d;
  logic [3:0]  err_q, err_d;
  logic        p3_v_q, p2_v_q, p1_v_q;
  logic        p3_v_d, p2_v_d, p1_v_d;
  logic        dq_oe_q, dq_oe_d;
  logic [15:0] dq_out_q, dq_out_d;

  // Datapath state (no reset; only meaningful while qualified by control state)
  logic [ROW_KEEP-1:0] row_q [4];
  logic [ROW_KEEP-1:0] row_d [4];
  logic [1:0]          b_ba_q, b_ba_d;
  logic [ROW_KEEP-1:0] b_row_q, b_row_d;
  logic [COL_BITS-1:0] b_col_q, b_col_d;
  logic [2:0]          b_beat_q, b_beat_d, b_mask_q, b_mask_d;
  logic                b_ap_q, b_ap_d;
  logic [MEM_AW-1:0]   p3_a_q, p2_a_q, p3_a_d, p2_a_d;
  logic [15:0]         rd_q;

  // Beat issued on this edge
  logic                iss, iss_wr, iss_ap, new_burst, stop;
  logic [1:0]          iss_ba;
  logic [ROW_KEEP-1:0] iss_row;
  logic [COL_BITS-1:0] iss_col;
  logic [2:0]          iss_beat, iss_mask, iss_lo;
  logic [MEM_AW-1:0]   iss_addr;
  logic                wr_en, rd_issue;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{sdram_addr[12:11], sdram_addr[9]};

  always_comb begin
    // NOTE: every _d and temporary takes a default first, so no branch can infer a latch.
    state_d = state_q;  cl3_d = cl3_q;  bl_mask_d = bl_mask_q;  init_d = init_q;
    open_d = open_q;  row_d = row_q;  err_d = err_q;
    b_ba_d = b_ba_q;  b_row_d = b_row_q;  b_col_d = b_col_q;
    b_beat_d = b_beat_q;  b_mask_d = b_mask_q;  b_ap_d = b_ap_q;
    iss = 1'b0;  iss_wr = 1'b0;  new_burst = 1'b0;
    iss_ba = b_ba_q;  iss_row = b_row_q;  iss_col = b_col_q;
    iss_beat = b_beat_q;  iss_mask = b_mask_q;  iss_ap = b_ap_q;

    // Terminate or precharge of the burst's bank stops beat issue this edge.
    stop = (cmd == CMD_BST) ||
           ((cmd == CMD_PRE) && (sdram_addr[10] || (sdram_ba == b_ba_q)));
    if (stop) state_d = B_IDLE;

    case (cmd)
      CMD_LMR: begin
        if (sdram_addr[6:4] == 3'd2 || sdram_addr[6:4] == 3'd3) begin
          cl3_d     = sdram_addr[4];
          // BL codes 0..3 map to mask 0,1,3,7; codes 4..7 fall back to BL=1.
          bl_mask_d = sdram_addr[2] ? 3'd0 :
                      {sdram_addr[1] & sdram_addr[0], sdram_addr[1], sdram_addr[1] | sdram_addr[0]};
          init_d    = 1'b1;
        end else begin
          err_d[3] = 1'b1;
        end
      end
      CMD_ACT: begin
        if (!init_q) err_d[2] = 1'b1;
        if (open_q[sdram_ba]) err_d[1] = 1'b1;
        open_d[sdram_ba] = 1'b1;
        row_d[sdram_ba]  = sdram_addr[ROW_KEEP-1:0];
      end
      CMD_PRE: begin
        if (sdram_addr[10]) open_d = 4'b0000;
        else                open_d[sdram_ba] = 1'b0;
      end
      CMD_RD, CMD_WR: begin
        if (!init_q) err_d[2] = 1'b1;
        if (!open_q[sdram_ba]) err_d[0] = 1'b1;
        else                   new_burst = 1'b1;
      end
      default: ;
    endcase

    if (new_burst) begin
      iss = 1'b1;  iss_wr = (cmd == CMD_WR);
      iss_ba = sdram_ba;  iss_row = row_q[sdram_ba];
      iss_col = sdram_addr[COL_BITS-1:0];  iss_beat = 3'd0;
      iss_mask = bl_mask_q;  iss_ap = sdram_addr[10];
    end else if (state_q != B_IDLE && !stop) begin
      iss = 1'b1;  iss_wr = (state_q == B_WRITE);
    end

    if (iss) begin
      b_ba_d = iss_ba;  b_row_d = iss_row;  b_col_d = iss_col;
      b_mask_d = iss_mask;  b_ap_d = iss_ap;  b_beat_d = iss_beat + 3'd1;
      if (iss_beat == iss_mask) begin
        state_d = B_IDLE;
        if (iss_ap) open_d[iss_ba] = 1'b0;
      end else begin
        state_d = iss_wr ? B_WRITE : B_READ;
      end
    end
  end

  // Column wraps inside the BL-aligned block: masked low bits count, the rest stay.
  assign iss_lo   = (iss_col[2:0] & ~iss_mask) | ((iss_col[2:0] + iss_beat) & iss_mask);
  assign iss_addr = {iss_ba, iss_row, iss_col[COL_BITS-1:3], iss_lo};
  assign wr_en    = iss && iss_wr;
  assign rd_issue = iss && !iss_wr;

  // Read pipeline: a beat enters at stage CL and leaves stage 1 onto the bus,
  // giving exactly CL edges from issue to drive. RAM is read as stage 2 drains.
  assign p3_v_d   = rd_issue && cl3_q;
  assign p3_a_d   = iss_addr;
  assign p2_v_d   = (rd_issue && !cl3_q) ? 1'b1 : p3_v_q;
  assign p2_a_d   = (rd_issue && !cl3_q) ? iss_addr : p3_a_q;
  assign p1_v_d   = p2_v_q;
  // A write beat on the bus wins over read data: the controller is driving dq.
  assign dq_oe_d  = p1_v_q && !wr_en;
  assign dq_out_d = p1_v_q ? rd_q : dq_out_q;

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q <= B_IDLE;  cl3_q <= 1'b1;  bl_mask_q <= 3'd0;  init_q <= 1'b0;
      open_q <= 4'b0000;  err_q <= 4'b0000;
      p3_v_q <= 1'b0;  p2_v_q <= 1'b0;  p1_v_q <= 1'b0;
      dq_oe_q <= 1'b0;  dq_out_q <= 16'h0000;
    end else if (sdram_cke) begin
      state_q <= state_d;  cl3_q <= cl3_d;  bl_mask_q <= bl_mask_d;  init_q <= init_d;
      open_q <= open_d;  err_q <= err_d;
      p3_v_q <= p3_v_d;  p2_v_q <= p2_v_d;  p1_v_q <= p1_v_d;
      dq_oe_q <= dq_oe_d;  dq_out_q <= dq_out_d;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (sdram_cke) begin
      row_q <= row_d;
      b_ba_q <= b_ba_d;  b_row_q <= b_row_d;  b_col_q <= b_col_d;
      b_beat_q <= b_beat_d;  b_mask_q <= b_mask_d;  b_ap_q <= b_ap_d;
      p3_a_q <= p3_a_d;  p2_a_q <= p2_a_d;
    end
  end

  // NOTE: storage has no reset so it maps onto block RAM and survives a reset.
  logic [15:0] mem [0:(1<<MEM_AW)-1];

  always_ff @(posedge clk_clk) begin
    if (sdram_cke) begin
      if (wr_en && !reset_reset) begin
        if (!sdram_dqm[0]) mem[iss_addr][7:0]  <= sdram_dq_in[7:0];
        if (!sdram_dqm[1]) mem[iss_addr][15:8] <= sdram_dq_in[15:8];
      end
      rd_q <= mem[p2_a_q];
    end
  end

  assign sdram_dq_out = dq_out_q;
  assign sdram_dq_oe  = dq_oe_q;
  assign init_done    = init_q;
  assign err_flags    = err_q;

endmodule

// File: tb/tb_sdram_responder.sv
// tb_sdram_responder
//   Directed test of sdram_responder. A command-level model (mode, open rows,
//   a word-addressed memory and a schedule of expected bus words keyed by
//   enabled-edge number) is compared against the DUT on every falling edge;
//   literal expectations on captured read beats pin the model itself.
module tb_sdram_responder;

  localparam logic [2:0] C_LMR = 3'b000, C_PRE = 3'b010, C_ACT = 3'b011,
                         C_WR  = 3'b100, C_RD  = 3'b101, C_BST = 3'b110;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic [12:0] sdram_addr;
  logic [1:0]  sdram_ba;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_cke;
  logic [1:0]  sdram_dqm;
  logic [15:0] sdram_dq_in;
  logic [15:0] sdram_dq_out;
  logic        sdram_dq_oe;
  logic        init_done;
  logic [3:0]  err_flags;

  sdram_responder dut (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .sdram_addr(sdram_addr), .sdram_ba(sdram_ba),
    .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n),
    .sdram_cke(sdram_cke), .sdram_dqm(sdram_dqm), .sdram_dq_in(sdram_dq_in),
    .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
    .init_done(init_done), .err_flags(err_flags)
  );

  always #5 clk_clk = ~clk_clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [15:0] mem_m [int];
  logic [15:0] sched [int];
  int          m_t, m_cl, m_bl;
  bit          m_init;
  bit          m_open [4];
  int          m_row  [4];
  logic [3:0]  m_err;
  bit          b_on, b_wr, b_ap;
  int          b_ba, b_row, b_col, b_n, b_bl;
  logic        cur_oe;
  logic [15:0] cur_dq;

  always @(posedge clk_clk) begin : model
    int c, ba, col, key;
    bit stop, wr_now;
    logic [12:0] a;
    logic [15:0] w;
    if (reset_reset) begin
      m_init = 0; m_cl = 3; m_bl = 1; m_err = 4'h0; b_on = 0;
      for (int i = 0; i < 4; i++) m_open[i] = 0;
      sched.delete();
      cur_oe = 1'b0; cur_dq = 16'h0000;
    end else if (sdram_cke) begin
      m_t++;
      wr_now = 0;
      c  = sdram_cs_n ? 7 : int'({sdram_ras_n, sdram_cas_n, sdram_we_n});
      ba = int'(sdram_ba);
      a  = sdram_addr;
      stop = (c == 6) || (c == 2 && (a[10] || ba == b_ba));
      if (stop) b_on = 0;
      case (c)
        0: if (a[6:4] == 3'd2 || a[6:4] == 3'd3) begin
             m_cl = int'(a[6:4]);
             m_bl = (a[2:0] < 3'd4) ? (1 << a[2:0]) : 1;
             m_init = 1;
           end else m_err[3] = 1'b1;
        3: begin
             if (!m_init) m_err[2] = 1'b1;
             if (m_open[ba]) m_err[1] = 1'b1;
             m_open[ba] = 1; m_row[ba] = int'(a);
           end
        2: if (a[10]) for (int i = 0; i < 4; i++) m_open[i] = 0;
           else m_open[ba] = 0;
        4, 5: begin
             if (!m_init) m_err[2] = 1'b1;
             if (!m_open[ba]) m_err[0] = 1'b1;
             else begin
               b_on = 1; b_wr = (c == 4); b_ba = ba; b_row = m_row[ba];
               b_col = int'(a[8:0]); b_n = 0; b_bl = m_bl; b_ap = a[10];
             end
           end
        default: ;
      endcase
      if (b_on) begin
        col = (b_col - b_col % b_bl) + (b_col + b_n) % b_bl;
        key = (b_ba * 8 + b_row % 8) * 512 + col;
        w = mem_m.exists(key) ? mem_m[key] : 16'h0000;
        if (b_wr) begin
          if (!sdram_dqm[0]) w[7:0]  = sdram_dq_in[7:0];
          if (!sdram_dqm[1]) w[15:8] = sdram_dq_in[15:8];
          mem_m[key] = w;
          wr_now = 1;
        end else begin
          sched[m_t + m_cl] = w;
        end
        b_n++;
        if (b_n == b_bl) begin
          b_on = 0;
          if (b_ap) m_open[b_ba] = 0;
        end
      end
      if (sched.exists(m_t)) begin
        cur_dq = sched[m_t];
        cur_oe = !wr_now;
        sched.delete(m_t);
      end else begin
        cur_oe = 1'b0;
      end
    end
  end

  always @(negedge clk_clk) begin
    if (chk_en) begin
      check("dq_oe", {15'd0, sdram_dq_oe}, {15'd0, cur_oe});
      if (cur_oe) check("dq_out", sdram_dq_out, cur_dq);
      check("init_done", {15'd0, init_done}, {15'd0, m_init});
      check("err_flags", {12'd0, err_flags}, {12'd0, m_err});
    end
  end

  // ---------------- read-beat capture ----------------
  int          cyc = 0;
  logic [15:0] obs [$];
  int          obs_cyc [$];

  always @(posedge clk_clk) begin : mon
    logic ck, rs;
    cyc++;
    ck = sdram_cke;
    rs = reset_reset;
    #2;
    if (!rs && ck && sdram_dq_oe) begin
      obs.push_back(sdram_dq_out);
      obs_cyc.push_back(cyc);
    end
  end

  function automatic logic [15:0] obs_at(input int i);
    return (obs.size() > i) ? obs[i] : 16'hDEAD;
  endfunction

  function automatic logic [15:0] lat_at(input int i, input int k);
    return (obs_cyc.size() > i) ? 16'(obs_cyc[i] - k) : 16'hDEAD;
  endfunction

  // ---------------- stimulus helpers ----------------
  logic [15:0] wd [8];
  int k;

  task automatic nop_bus();
    sdram_cs_n = 1'b1; sdram_ras_n = 1'b1; sdram_cas_n = 1'b1; sdram_we_n = 1'b1;
    sdram_addr = '0; sdram_ba = '0; sdram_dqm = '0; sdram_dq_in = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_clk);
      #1;
    end
  endtask

  task automatic drive(input logic [2:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [15:0] dq, input logic [1:0] dqm);
    sdram_cs_n = 1'b0;
    {sdram_ras_n, sdram_cas_n, sdram_we_n} = c;
    sdram_ba = ba; sdram_addr = a; sdram_dq_in = dq; sdram_dqm = dqm;
    @(posedge clk_clk);
    #1;
    nop_bus();
  endtask

  task automatic write_burst(input logic [1:0] ba, input logic [12:0] a, input int n);
    drive(C_WR, ba, a, wd[0], 2'b00);
    for (int i = 1; i < n; i++) begin
      sdram_dq_in = wd[i];
      @(posedge clk_clk);
      #1;
    end
    sdram_dq_in = '0;
  endtask

  task automatic read_at(input logic [1:0] ba, input logic [12:0] a);
    obs.delete();
    obs_cyc.delete();
    drive(C_RD, ba, a, 16'h0, 2'b00);
    k = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    nop_bus();
    sdram_cke = 1'b1;
    reset_reset = 1'b1;
    idle(3);
    reset_reset = 1'b0;
    chk_en = 1'b1;
    check("reset init_done", {15'd0, init_done}, 16'd0);
    check("reset err_flags", {12'd0, err_flags}, 16'd0);
    check("reset dq_oe", {15'd0, sdram_dq_oe}, 16'd0);
    check("reset dq_out", sdram_dq_out, 16'h0000);

    // Basic CL=3 BL=4 write/read
    drive(C_LMR, 2'd0, 13'h032, 16'h0, 2'b00);
    check("lmr init_done", {15'd0, init_done}, 16'd1);
    drive(C_ACT, 2'd1, 13'd5, 16'h0, 2'b00);
    wd = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h0, 16'h0, 16'h0, 16'h0};
    write_burst(2'd1, 13'd8, 4);
    idle(2);
    read_at(2'd1, 13'd8);
    idle(8);
    check("cl3 beats", 16'(obs.size()), 16'd4);
    check("cl3 first latency", lat_at(0, k), 16'd3);
    check("cl3 last latency", lat_at(3, k), 16'd6);
    check("cl3 beat0", obs_at(0), 16'h1111);
    check("cl3 beat3", obs_at(3), 16'h4444);

    // Wrap inside BL-aligned block, CL=2
    drive(C_LMR, 2'd0, 13'h022, 16'h0, 2'b00);
    write_burst(2'd1, 13'd8, 4);
    idle(2);
    read_at(2'd1, 13'd10);
    idle(8);
    check("wrap latency", lat_at(0, k), 16'd2);
    check("wrap beat0", obs_at(0), 16'h3333);
    check("wrap beat1", obs_at(1), 16'h4444);
    check("wrap beat2", obs_at(2), 16'h1111);
    check("wrap beat3", obs_at(3), 16'h2222);

    // Byte mask, BL=1
    drive(C_LMR, 2'd0, 13'h020, 16'h0, 2'b00);
    drive(C_WR, 2'd1, 13'd20, 16'h1234, 2'b00);
    drive(C_WR, 2'd1, 13'd20, 16'hABCD, 2'b10);
    idle(2);
    read_at(2'd1, 13'd20);
    idle(6);
    check("mask beats", 16'(obs.size()), 16'd1);
    check("mask data", obs_at(0), 16'h12CD);

    // Protocol errors
    read_at(2'd0, 13'd0);
    idle(6);
    check("closed err", {12'd0, err_flags}, 16'h0001);
    check("closed no beats", 16'(obs.size()), 16'd0);
    drive(C_ACT, 2'd2, 13'd7, 16'h0, 2'b00);
    drive(C_ACT, 2'd2, 13'd9, 16'h0, 2'b00);
    check("double act err", {12'd0, err_flags}, 16'h0003);
    drive(C_LMR, 2'd0, 13'h052, 16'h0, 2'b00);
    check("bad cl err", {12'd0, err_flags}, 16'h000B);
    read_at(2'd1, 13'd20);
    idle(6);
    check("kept cl2 latency", lat_at(0, k), 16'd2);
    check("kept bl1 beats", 16'(obs.size()), 16'd1);

    // Terminate and auto-precharge (fresh error state, RAM kept)
    reset_reset = 1'b1;
    idle(2);
    reset_reset = 1'b0;
    check("rst2 err_flags", {12'd0, err_flags}, 16'd0);
    check("rst2 init_done", {15'd0, init_done}, 16'd0);
    drive(C_LMR, 2'd0, 13'h033, 16'h0, 2'b00);
    drive(C_ACT, 2'd1, 13'd5, 16'h0, 2'b00);
    for (int i = 0; i < 8; i++) wd[i] = 16'h1000 + 16'(i);
    write_burst(2'd1, 13'd0, 8);
    idle(2);
    read_at(2'd1, 13'd0);
    idle(1);
    drive(C_BST, 2'd0, 13'd0, 16'h0, 2'b00);
    idle(8);
    check("bst beats", 16'(obs.size()), 16'd2);
    check("bst beat1", obs_at(1), 16'h1001);
    read_at(2'd1, 13'h400);
    idle(14);
    check("ap beats", 16'(obs.size()), 16'd8);
    check("ap beat7", obs_at(7), 16'h1007);
    read_at(2'd1, 13'd0);
    idle(6);
    check("after ap err", {12'd0, err_flags}, 16'h0001);
    check("after ap no beats", 16'(obs.size()), 16'd0);

    // cke freeze mid-read
    drive(C_LMR, 2'd0, 13'h032, 16'h0, 2'b00);
    drive(C_ACT, 2'd1, 13'd5, 16'h0, 2'b00);
    read_at(2'd1, 13'd8);
    idle(4);
    check("pre-freeze dq_out", sdram_dq_out, 16'h2222);
    sdram_cke = 1'b0;
    idle(3);
    check("frozen dq_oe", {15'd0, sdram_dq_oe}, 16'd1);
    check("frozen dq_out", sdram_dq_out, 16'h2222);
    sdram_cke = 1'b1;
    idle(6);
    check("resume beats", 16'(obs.size()), 16'd4);
    check("resume beat2", obs_at(2), 16'h3333);
    check("resume beat3", obs_at(3), 16'h4444);

    // Reset mid-burst; storage survives (row 13 aliases row 5)
    read_at(2'd1, 13'd8);
    idle(4);
    reset_reset = 1'b1;
    idle(1);
    check("midrst dq_oe", {15'd0, sdram_dq_oe}, 16'd0);
    reset_reset = 1'b0;
    drive(C_LMR, 2'd0, 13'h032, 16'h0, 2'b00);
    drive(C_ACT, 2'd1, 13'd13, 16'h0, 2'b00);
    read_at(2'd1, 13'd8);
    idle(8);
    check("retain beats", 16'(obs.size()), 16'd4);
    check("retain beat0", obs_at(0), 16'h1111);
    check("retain beat3", obs_at(3), 16'h4444);
    check("retain err", {12'd0, err_flags}, 16'd0);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
